// File: rtl/vec_strided_load_unit_if.sv
// Interface bundle for the strided vector load engine: dispatch request, completion status,
// packed destination image and the word-wide read port toward memory.
// Modports: slave = load engine side, master = dispatch/memory environment side.
// Ports carried: start/base/stride/vl/sew in, busy/done/err/vreg_data out, mem_* read port.
interface vec_strided_load_unit_if #(
    parameter int VLEN = 256,
    parameter int VLW  = $clog2(VLEN/8) + 1
);
    logic             start;
    logic [31:0]      base;
    logic [31:0]      stride;
    logic [VLW-1:0]   vl;
    logic [1:0]       sew;
    logic             busy;
    logic             done;
    logic             err;
    logic [VLEN-1:0]  vreg_data;
    logic             mem_valid;
    logic             mem_ready;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_rdata;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_wdata;

    modport slave (
        input  start, base, stride, vl, sew, mem_ready, mem_rdata,
        output busy, done, err, vreg_data, mem_valid, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output start, base, stride, vl, sew, mem_ready, mem_rdata,
        input  busy, done, err, vreg_data, mem_valid, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/vec_strided_load_unit.sv
// Strided vector load: fetches vl elements of SEW bits at base + i*stride and packs them into one VLEN image.
// Latency: 1 + 3*vl + 1 cycles start->done with zero-wait memory; each memory stall adds one cycle.
// Backpressure: mem_valid holds with a stable address until mem_ready; start is ignored while busy.
// Ports: clk, resetn (async active-low), bus (slave modport: request, status, result, memory read port).
module vec_strided_load_unit #(
    parameter int VLEN = 256,
    parameter int VLW  = $clog2(VLEN/8) + 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    vec_strided_load_unit_if.slave  bus
);

    localparam int N8  = VLEN / 8;
    localparam int N16 = VLEN / 16;
    localparam int N32 = VLEN / 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_STEP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [31:0]      r_addr;
    logic [31:0]      r_stride;
    logic [1:0]       r_sew;
    logic [VLW-1:0]   r_vl_eff;
    logic [VLW-1:0]   r_idx;
    logic             r_err_pend;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_mem_valid;
    logic [31:0]      r_mem_addr;
    logic [VLEN-1:0]  r_vreg_data;

    logic [VLW-1:0]   w_cap;
    logic [VLW-1:0]   w_vl_eff;
    logic             w_misaligned;
    logic [7:0]       w_lane8;
    logic [15:0]      w_lane16;
    logic [VLEN-1:0]  w_vreg_next;

    // Element count is clamped to what fits in one register at the requested SEW.
    always_comb begin
        w_cap = VLW'(N32);
        case (bus.sew)
            2'b00:   w_cap = VLW'(N8);
            2'b01:   w_cap = VLW'(N16);
            default: w_cap = VLW'(N32);
        endcase
        w_vl_eff = (bus.vl > w_cap) ? w_cap : bus.vl;
    end

    // Element must sit entirely inside one memory word; reserved SEW always faults.
    always_comb begin
        w_misaligned = 1'b0;
        case (r_sew)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = r_addr[0];
            2'b10:   w_misaligned = (r_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        w_lane8 = bus.mem_rdata[7:0];
        case (r_addr[1:0])
            2'b00:   w_lane8 = bus.mem_rdata[7:0];
            2'b01:   w_lane8 = bus.mem_rdata[15:8];
            2'b10:   w_lane8 = bus.mem_rdata[23:16];
            default: w_lane8 = bus.mem_rdata[31:24];
        endcase
        w_lane16 = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    end

    // Insert the returned lane into slot r_idx; every other slot keeps its value.
    always_comb begin
        w_vreg_next = r_vreg_data;
        case (r_sew)
            2'b00: begin
                for (int i = 0; i < N8; i++) begin
                    if (r_idx == VLW'(i)) w_vreg_next[i*8 +: 8] = w_lane8;
                end
            end
            2'b01: begin
                for (int i = 0; i < N16; i++) begin
                    if (r_idx == VLW'(i)) w_vreg_next[i*16 +: 16] = w_lane16;
                end
            end
            2'b10: begin
                for (int i = 0; i < N32; i++) begin
                    if (r_idx == VLW'(i)) w_vreg_next[i*32 +: 32] = bus.mem_rdata;
                end
            end
            default: w_vreg_next = r_vreg_data;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_stride    <= '0;
            r_sew       <= '0;
            r_vl_eff    <= '0;
            r_idx       <= '0;
            r_err_pend  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_vreg_data <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_addr      <= bus.base;
                        r_stride    <= bus.stride;
                        r_sew       <= bus.sew;
                        r_vl_eff    <= w_vl_eff;
                        r_idx       <= '0;
                        r_err_pend  <= 1'b0;
                        r_vreg_data <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // Reserved SEW faults before the count test so vl=0 cannot mask it.
                    if (r_sew == 2'b11) begin
                        r_err_pend <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (r_idx == r_vl_eff) begin
                        r_err_pend <= 1'b0;
                        r_state    <= S_DONE;
                    end else if (w_misaligned) begin
                        r_err_pend <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= {r_addr[31:2], 2'b00};
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_vreg_data <= w_vreg_next;
                        r_state     <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_idx   <= r_idx + 1'b1;
                    r_addr  <= r_addr + r_stride;
                    r_state <= S_CHECK;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_err   <= r_err_pend;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.vreg_data = r_vreg_data;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wstrb = 4'b0000;
    assign bus.mem_wdata = 32'h0000_0000;

endmodule

// File: tb/tb_vec_strided_load_unit.sv
// Directed bench for the strided vector load engine with a queue-based scoreboard.
module tb_vec_strided_load_unit;
    localparam int VLEN = 256;
    localparam int VLW  = $clog2(VLEN/8) + 1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    vec_strided_load_unit_if #(.VLEN(VLEN), .VLW(VLW)) bif();

    vec_strided_load_unit #(.VLEN(VLEN), .VLW(VLW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    typedef struct {
        logic [VLEN-1:0] vreg;
        logic            err;
        int              hs;
        int              lat;
        int              start_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] mem [0:7];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hs_cnt  = 0;
    int wcnt    = 0;
    int wait_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    function automatic logic [31:0] lookup(input logic [31:0] a);
        if (a >= 32'd400 && a < 32'd432) return mem[int'((a - 32'd400) >> 2)];
        return 32'hDEAD_BEEF;
    endfunction

    // Memory responder and completion monitor, sampled on the falling edge.
    task automatic monitor_step();
        exp_t e;
        if (!resetn) begin
            bif.mem_ready = 1'b0;
            wcnt   = 0;
            hs_cnt = 0;
            addr_q.delete();
            return;
        end
        if (bif.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("vreg_data", bif.vreg_data, e.vreg);
                chk("err", bif.err, e.err);
                chk("handshakes", hs_cnt, e.hs);
                if (e.lat >= 0) chk("latency", cyc - e.start_cyc, e.lat);
                chk("addr_left", addr_q.size(), 0);
            end
            hs_cnt = 0;
        end
        if (bif.mem_valid && !bif.mem_ready) begin
            if (wcnt >= wait_cycles) begin
                bif.mem_ready = 1'b1;
                bif.mem_rdata = lookup(bif.mem_addr);
                wcnt = 0;
                hs_cnt++;
                if (addr_q.size() == 0) chk("extra_request", 1, 0);
                else chk("mem_addr", bif.mem_addr, addr_q.pop_front());
                chk("mem_write_zero", {bif.mem_wstrb, bif.mem_wdata}, 0);
            end else begin
                wcnt++;
            end
        end else begin
            bif.mem_ready = 1'b0;
        end
    endtask

    task automatic run(input logic [1:0] s, input logic [31:0] b, input logic [31:0] st,
                       input logic [VLW-1:0] v, input logic [VLEN-1:0] ev, input logic ee,
                       input int ehs, input int elat, input bit expect_done);
        exp_t e;
        @(negedge clk);
        if (expect_done) begin
            for (int i = 0; i < ehs; i++) addr_q.push_back((b + st * i) & 32'hFFFF_FFFC);
            e.vreg = ev; e.err = ee; e.hs = ehs; e.lat = elat; e.start_cyc = cyc + 1;
            exp_q.push_back(e);
        end
        bif.start = 1'b1; bif.sew = s; bif.base = b; bif.stride = st; bif.vl = v;
        @(negedge clk);
        bif.start = 1'b0;
        chk("busy_after_start", bif.busy, 1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_timeout", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, bif.busy, 0);
        chk({tag, "_done"}, bif.done, 0);
        chk({tag, "_err"}, bif.err, 0);
        chk({tag, "_mem_valid"}, bif.mem_valid, 0);
        chk({tag, "_mem_addr"}, bif.mem_addr, 0);
        chk({tag, "_vreg_data"}, bif.vreg_data, 0);
    endtask

    initial begin
        mem[0] = 32'h0403_0201; mem[1] = 32'h0807_0605;
        mem[2] = 32'h0c0b_0a09; mem[3] = 32'h000f_0e0d;
        mem[4] = 32'h1312_1110; mem[5] = 32'h1716_1514;
        mem[6] = 32'h1b1a_1918; mem[7] = 32'h1f1e_1d1c;
        bif.start = 1'b0; bif.base = '0; bif.stride = '0; bif.vl = '0; bif.sew = '0;
        bif.mem_ready = 1'b0; bif.mem_rdata = '0;
        resetn = 1'b0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            begin
                repeat (3) @(negedge clk);
                check_outputs_zero("reset");
                resetn = 1'b1;
                repeat (2) @(negedge clk);

                // sew8, stride 2, odd bytes
                run(2'b00, 32'd400, 32'd2, 6'd8, 256'h0f0d0b0907050301, 1'b0, 8, 26, 1'b1);
                wait_drain();
                // sew16, stride 4
                run(2'b01, 32'd400, 32'd4, 6'd4, 256'h0e0d0a0906050201, 1'b0, 4, 14, 1'b1);
                wait_drain();
                // sew32, negative stride
                run(2'b10, 32'd412, 32'hFFFF_FFFC, 6'd3, 256'h08070605_0c0b0a09_000f0e0d, 1'b0, 3, 11, 1'b1);
                wait_drain();
                // sew32 misaligned first element
                run(2'b10, 32'd401, 32'd4, 6'd4, 256'h0, 1'b1, 0, 2, 1'b1);
                wait_drain();
                // sew16 misaligned at element 1 (addr 403)
                run(2'b01, 32'd400, 32'd3, 6'd4, 256'h0201, 1'b1, 1, 5, 1'b1);
                wait_drain();
                // vl = 0
                run(2'b00, 32'd400, 32'd1, 6'd0, 256'h0, 1'b0, 0, 2, 1'b1);
                wait_drain();
                // vl = 40 clamped to 32 bytes
                run(2'b00, 32'd400, 32'd1, 6'd40,
                    256'h1f1e1d1c_1b1a1918_17161514_13121110_000f0e0d_0c0b0a09_08070605_04030201,
                    1'b0, 32, 98, 1'b1);
                wait_drain();
                // stride 0: same word three times
                run(2'b10, 32'd404, 32'd0, 6'd3, 256'h08070605_08070605_08070605, 1'b0, 3, 11, 1'b1);
                wait_drain();
                // reserved sew
                run(2'b11, 32'd400, 32'd4, 6'd4, 256'h0, 1'b1, 0, 2, 1'b1);
                wait_drain();
                // memory stalls, upper half then lower half
                wait_cycles = 2;
                run(2'b01, 32'd402, 32'hFFFF_FFFE, 6'd2, 256'h0201_0403, 1'b0, 2, -1, 1'b1);
                wait_drain();
                wait_cycles = 0;

                // start pulsed while busy is ignored
                run(2'b00, 32'd404, 32'd1, 6'd2, 256'h0605, 1'b0, 2, 8, 1'b1);
                @(negedge clk);
                bif.start = 1'b1; bif.sew = 2'b10; bif.base = 32'd400; bif.stride = 32'd4; bif.vl = 6'd8;
                @(negedge clk);
                bif.start = 1'b0;
                wait_drain();
                repeat (20) @(negedge clk);

                // reset while a request is outstanding
                wait_cycles = 20;
                run(2'b10, 32'd400, 32'd4, 6'd4, 256'h0, 1'b0, 0, 0, 1'b0);
                for (int k = 0; k < 20 && !bif.mem_valid; k++) @(negedge clk);
                chk("reach_mem_valid", bif.mem_valid, 1);
                resetn = 1'b0;
                #1;
                check_outputs_zero("midreset");
                repeat (3) @(negedge clk);
                resetn = 1'b1;
                wait_cycles = 0;
                repeat (10) @(negedge clk);

                // recovery after abandoned transfer
                run(2'b01, 32'd400, 32'd4, 6'd4, 256'h0e0d0a0906050201, 1'b0, 4, 14, 1'b1);
                wait_drain();
                chk("queue_empty", exp_q.size(), 0);
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
